// File: rtl/lcd_cmd_arbiter.sv
// Round-robin arbiter for the shared LCD command port: runs the boot init
// command, then grants one requester command at a time with completion/timeout and a guard gap.
module lcd_cmd_arbiter #(
  parameter int unsigned SIZE_DATA   = 8,
  parameter int unsigned SIZE_FUNC   = 4,
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned GAP_CYC     = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ*SIZE_FUNC-1:0]   i_func,
  input  logic [NUM_REQ*SIZE_DATA-1:0]   i_data,
  output logic [NUM_REQ-1:0]             o_gnt,
  output logic [NUM_REQ-1:0]             o_ack,
  output logic [NUM_REQ-1:0]             o_err,
  output logic                           o_en_lcd,
  output logic [SIZE_FUNC-1:0]           o_func,
  output logic [SIZE_DATA-1:0]           o_data,
  input  logic                           i_done_LCD,
  output logic                           o_init_done,
  output logic                           o_busy
);

  localparam int unsigned IDX_W   = $clog2(NUM_REQ);
  localparam int unsigned CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [SIZE_FUNC-1:0] FUNC_INIT = '0;

  typedef enum logic [2:0] {
    S_BOOT,
    S_BOOT_WAIT,
    S_IDLE,
    S_WAIT,
    S_GAP
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic                 en_q, en_d;
  logic [SIZE_FUNC-1:0] func_q, func_d;
  logic [SIZE_DATA-1:0] data_q, data_d;
  logic                 init_done_q, init_done_d;
  logic                 busy_q, busy_d;

  logic                 found;
  logic [IDX_W-1:0]     sel;
  logic [IDX_W-1:0]     cand;
  logic                 timeout_hit;
  logic                 gap_last;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign gap_last    = (cnt_q == CNT_W'(GAP_CYC - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_BOOT;
      ptr_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      en_q        <= 1'b0;
      func_q      <= '0;
      data_q      <= '0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      en_q        <= en_d;
      func_q      <= func_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    ack_d       = '0;
    err_d       = '0;
    en_d        = 1'b0;
    func_d      = func_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    found       = 1'b0;
    sel         = '0;
    cand        = '0;

    // First asserted request at or after the round-robin pointer
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && i_req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end

    case (state_q)
      S_BOOT: begin
        en_d    = 1'b1;
        func_d  = FUNC_INIT;
        data_d  = '0;
        cnt_d   = '0;
        state_d = S_BOOT_WAIT;
      end
      S_BOOT_WAIT: begin
        if (i_done_LCD) begin
          init_done_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_GAP;
        end else if (timeout_hit) begin
          state_d = S_BOOT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (found) begin
          idx_d      = sel;
          gnt_d[sel] = 1'b1;
          en_d       = 1'b1;
          func_d     = i_func[32'(sel)*SIZE_FUNC +: SIZE_FUNC];
          data_d     = i_data[32'(sel)*SIZE_DATA +: SIZE_DATA];
          ptr_d      = (32'(sel) == NUM_REQ - 1) ? '0 : sel + IDX_W'(1);
          cnt_d      = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // done takes priority over a timeout landing in the same cycle
        if (i_done_LCD || timeout_hit) begin
          if (i_done_LCD) begin
            ack_d[idx_q] = 1'b1;
          end else begin
            err_d[idx_q] = 1'b1;
          end
          func_d  = '0;
          data_d  = '0;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (gap_last) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_BOOT;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign o_gnt       = gnt_q;
  assign o_ack       = ack_q;
  assign o_err       = err_q;
  assign o_en_lcd    = en_q;
  assign o_func      = func_q;
  assign o_data      = data_q;
  assign o_init_done = init_done_q;
  assign o_busy      = busy_q;

endmodule
